weight_tile_sched: RTL and testbench

- Sequencer for the weight-buffer datapath (temp buffer → P weight DPRs → PE array).
- Accepts a command of N weight tiles and, for each tile, streams M*M elements from main memory into the temp buffer via the weight block's load path.
- Waits for the weight block's load_done, then runs one execution pass on the start level and waits for the PE side to report completion.
- Drives the main-memory read port that the weight block leaves unconnected.

---
 rtl/weight_tile_sched.sv | 215 +++++++++++++++++++++
 tb/tb_weight_tile_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/weight_tile_sched.sv
// weight_tile_sched: sequencer for the weight-buffer datapath
// (temp buffer -> P weight DPRs -> PE array).
//
// For each of N tiles it streams M*M words from main memory into the weight block's
// temp buffer, waits for the load to complete, runs one execution pass and waits for
// the PE side to report completion.
//
// Optional feature (macro WTS_WATCHDOG_EN): a WD_BITS-bit watchdog on WAIT_LOAD/EXEC
// that parks the FSM in ERR with a sticky err flag. Undefined: err is tied to 0 and the
// FSM waits indefinitely.
//
// Ports:
//   sys_clk, reset_n          clock (posedge), asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake; fields cmd_num_tiles, cmd_base_addr
//   mem_addr/mem_cs/mem_oe    main-memory read port
//   wt_load/wt_load_done      load level / completion pulse to/from the weight block
//   wt_start                  execution level to the weight block
//   exec_done_async           execution-done level from the PE clock domain
//   tile_idx, busy, done, err status

module weight_tile_sched #(
  parameter int unsigned FEATURE_BITS = 4,
  parameter int unsigned M            = 9,
  parameter int unsigned ADDR_BITS    = 16,
  parameter int unsigned TILE_BITS    = 4,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned WD_BITS      = 12
) (
  input  logic                 sys_clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [TILE_BITS-1:0] cmd_num_tiles,
  input  logic [ADDR_BITS-1:0] cmd_base_addr,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_cs,
  output logic                 mem_oe,
  output logic                 wt_load,
  input  logic                 wt_load_done,
  output logic                 wt_start,
  input  logic                 exec_done_async,
  output logic [TILE_BITS-1:0] tile_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned CntBits = 2 * FEATURE_BITS;
  localparam logic [CntBits-1:0] LastWord = CntBits'(M * M - 1);
  localparam logic [CntBits-1:0] LoadWord = CntBits'(MEM_LAT);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitLoad,
    StExec,
    StNext,
    StFin
`ifdef WTS_WATCHDOG_EN
    , StErr
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [TILE_BITS-1:0] n_tiles_q, n_tiles_d;
  logic [TILE_BITS-1:0] tile_idx_q, tile_idx_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [CntBits-1:0]   word_cnt_q, word_cnt_d;
  logic                 load_seen_q, load_seen_d;
  logic [2:0]           exec_sync_q;
  logic                 exec_rise_q;

  logic                 idle_like;
  logic                 accept;
  logic [TILE_BITS-1:0] last_tile;

`ifdef WTS_WATCHDOG_EN
  // Expires when the counter would reach all-ones at the end of this cycle.
  localparam logic [WD_BITS-1:0] WdLast = {{(WD_BITS - 1){1'b1}}, 1'b0};
  logic [WD_BITS-1:0] wd_q, wd_d;

  assign idle_like = (state_q == StIdle) || (state_q == StErr);
  assign err       = (state_q == StErr);
`else
  logic unused_wd_bits;
  assign unused_wd_bits = ^WD_BITS;

  assign idle_like = (state_q == StIdle);
  assign err       = 1'b0;
`endif

  assign accept    = cmd_valid && idle_like;
  assign last_tile = n_tiles_q - 1'b1;

  // Outputs decode from registered state only.
  assign cmd_ready = idle_like;
  assign busy      = (state_q != StIdle);
  assign mem_cs    = (state_q == StFetch);
  assign mem_oe    = mem_cs;
  assign mem_addr  = mem_cs ? addr_q : '0;
  // Delay wt_load by MEM_LAT so the first read word lines up with the first buffer write.
  assign wt_load   = ((state_q == StFetch) && (word_cnt_q >= LoadWord)) ||
                     (state_q == StWaitLoad);
  assign wt_start  = (state_q == StExec);
  assign done      = (state_q == StFin);
  assign tile_idx  = tile_idx_q;

  always_comb begin
    state_d     = state_q;
    n_tiles_d   = n_tiles_q;
    tile_idx_d  = tile_idx_q;
    addr_d      = addr_q;
    word_cnt_d  = word_cnt_q;
    load_seen_d = load_seen_q;

    case (state_q)
      StIdle: state_d = StIdle;
      StFetch: begin
        // Tiles are contiguous, so the address simply keeps counting across tiles.
        addr_d     = addr_q + 1'b1;
        word_cnt_d = word_cnt_q + 1'b1;
        if (wt_load_done) load_seen_d = 1'b1;
        if (word_cnt_q == LastWord) begin
          word_cnt_d = '0;
          state_d    = (load_seen_q || wt_load_done) ? StExec : StWaitLoad;
        end
      end
      StWaitLoad: begin
        // A coincident exec_rise is dropped: EXEC only looks at later rises.
        if (wt_load_done) state_d = StExec;
`ifdef WTS_WATCHDOG_EN
        else if (wd_q == WdLast) state_d = StErr;
`endif
      end
      StExec: begin
        if (exec_rise_q) state_d = StNext;
`ifdef WTS_WATCHDOG_EN
        else if (wd_q == WdLast) state_d = StErr;
`endif
      end
      StNext: begin
        if (tile_idx_q == last_tile) begin
          state_d = StFin;
        end else begin
          tile_idx_d  = tile_idx_q + 1'b1;
          load_seen_d = 1'b0;
          state_d     = StFetch;
        end
      end
      StFin: state_d = StIdle;
`ifdef WTS_WATCHDOG_EN
      StErr: state_d = StErr;
`endif
      default: state_d = StIdle;
    endcase

    if (accept) begin
      n_tiles_d   = cmd_num_tiles;
      addr_d      = cmd_base_addr;
      tile_idx_d  = '0;
      word_cnt_d  = '0;
      load_seen_d = 1'b0;
      state_d     = (cmd_num_tiles == '0) ? StFin : StFetch;
    end
  end

`ifdef WTS_WATCHDOG_EN
  // Clears on entry to WAIT_LOAD/EXEC, counts every cycle spent there.
  always_comb begin
    wd_d = '0;
    if (((state_d == StWaitLoad) || (state_d == StExec)) && (state_d == state_q)) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      n_tiles_q   <= '0;
      tile_idx_q  <= '0;
      addr_q      <= '0;
      word_cnt_q  <= '0;
      load_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_tiles_q   <= n_tiles_d;
      tile_idx_q  <= tile_idx_d;
      addr_q      <= addr_d;
      word_cnt_q  <= word_cnt_d;
      load_seen_q <= load_seen_d;
    end
  end

  // Two-flop synchronizer, then a registered rising-edge detect:
  // three cycles from the input edge to exec_rise_q.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      exec_sync_q <= '0;
      exec_rise_q <= 1'b0;
    end else begin
      exec_sync_q <= {exec_sync_q[1:0], exec_done_async};
      exec_rise_q <= exec_sync_q[1] & ~exec_sync_q[2];
    end
  end

endmodule

// File: tb/tb_weight_tile_sched.sv
// Directed self-checking bench for weight_tile_sched (M=9, MEM_LAT=1, 16-bit addresses).
// Status flags are packed as {cmd_ready, busy, mem_cs, mem_oe, wt_load, wt_start, done, err}.

module tb_weight_tile_sched;

  localparam int unsigned M      = 9;
  localparam int unsigned MM     = M * M;
  localparam int unsigned MemLat = 1;

  localparam logic [7:0] FlIdle     = 8'h80;
  localparam logic [7:0] FlFetch    = 8'h70;
  localparam logic [7:0] FlFetchLd  = 8'h78;
  localparam logic [7:0] FlWaitLoad = 8'h48;
  localparam logic [7:0] FlExec     = 8'h44;
  localparam logic [7:0] FlNext     = 8'h40;
  localparam logic [7:0] FlFin      = 8'h42;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_num_tiles = '0;
  logic [15:0] cmd_base_addr = '0;
  logic [15:0] mem_addr;
  logic        mem_cs, mem_oe, wt_load, wt_start, busy, done, err;
  logic        wt_load_done = 1'b0;
  logic        exec_done_async = 1'b0;
  logic [3:0]  tile_idx;
  logic [7:0]  flags;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 sys_clk = ~sys_clk;

  assign flags = {cmd_ready, busy, mem_cs, mem_oe, wt_load, wt_start, done, err};

  weight_tile_sched #(
    .FEATURE_BITS(4),
    .M           (M),
    .ADDR_BITS   (16),
    .TILE_BITS   (4),
    .MEM_LAT     (MemLat),
    .WD_BITS     (4)
  ) dut (
    .sys_clk        (sys_clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_num_tiles  (cmd_num_tiles),
    .cmd_base_addr  (cmd_base_addr),
    .mem_addr       (mem_addr),
    .mem_cs         (mem_cs),
    .mem_oe         (mem_oe),
    .wt_load        (wt_load),
    .wt_load_done   (wt_load_done),
    .wt_start       (wt_start),
    .exec_done_async(exec_done_async),
    .tile_idx       (tile_idx),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Accept a command; returns sampled in the first cycle after the accept edge.
  task automatic issue(input logic [3:0] n, input logic [15:0] base);
    cmd_valid     = 1'b1;
    cmd_num_tiles = n;
    cmd_base_addr = base;
    tick();
    cmd_valid     = 1'b0;
  endtask

  // Entered in the first FETCH cycle of a tile; returns sampled in NEXT.
  task automatic do_tile(input logic [15:0] start, input logic [3:0] idx);
    logic [15:0] a;
    for (int i = 0; i < int'(MM); i++) begin
      a = start + 16'(i);
      check_eq("fetch_flags", flags, (i >= int'(MemLat)) ? FlFetchLd : FlFetch);
      check_eq("fetch_addr", mem_addr, a);
      check_eq("fetch_idx", tile_idx, idx);
      tick();
    end
    check_eq("wait_flags", flags, FlWaitLoad);
    tick();
    tick();
    check_eq("wait_hold", flags, FlWaitLoad);
    wt_load_done = 1'b1;
    tick();
    wt_load_done = 1'b0;
    check_eq("exec_flags", flags, FlExec);
    tick();
    exec_done_async = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("exec_hold", flags, FlExec);
    end
    tick();
    check_eq("next_flags", flags, FlNext);
    exec_done_async = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check_eq("reset_flags", flags, FlIdle);
    check_eq("reset_addr", mem_addr, 16'h0000);
    check_eq("reset_idx", tile_idx, 4'd0);
    reset_n = 1'b1;
    tick();
    check_eq("idle_flags", flags, FlIdle);

    // Single tile at 0x0100
    issue(4'd1, 16'h0100);
    do_tile(16'h0100, 4'd0);
    tick();
    check_eq("t1_fin", flags, FlFin);
    tick();
    check_eq("t1_idle", flags, FlIdle);
    check_eq("t1_idx_hold", tile_idx, 4'd0);

    // Three tiles with address wrap: 0xFFC0, 0x0011, 0x0062
    issue(4'd3, 16'hFFC0);
    do_tile(16'hFFC0, 4'd0);
    tick();
    do_tile(16'h0011, 4'd1);
    tick();
    do_tile(16'h0062, 4'd2);
    tick();
    check_eq("t3_fin", flags, FlFin);
    check_eq("t3_idx", tile_idx, 4'd2);
    tick();
    check_eq("t3_idle", flags, FlIdle);
    check_eq("t3_idx_hold", tile_idx, 4'd2);

    // Zero tiles: straight to FIN
    issue(4'd0, 16'h1234);
    check_eq("z_fin", flags, FlFin);
    check_eq("z_addr", mem_addr, 16'h0000);
    check_eq("z_idx", tile_idx, 4'd0);
    tick();
    check_eq("z_idle", flags, FlIdle);

    // Back-pressure: new fields held on cmd_valid during a run
    cmd_valid     = 1'b1;
    cmd_num_tiles = 4'd1;
    cmd_base_addr = 16'h0200;
    tick();
    cmd_num_tiles = 4'd2;
    cmd_base_addr = 16'h0300;
    do_tile(16'h0200, 4'd0);
    tick();
    check_eq("bp_fin", flags, FlFin);
    tick();
    check_eq("bp_idle", flags, FlIdle);
    tick();
    cmd_valid = 1'b0;
    do_tile(16'h0300, 4'd0);
    tick();
    do_tile(16'h0351, 4'd1);
    tick();
    check_eq("bp2_fin", flags, FlFin);
    check_eq("bp2_idx", tile_idx, 4'd1);
    tick();
    check_eq("bp2_idle", flags, FlIdle);

    // Asynchronous reset mid-FETCH
    issue(4'd1, 16'h0400);
    repeat (5) tick();
    check_eq("rst_pre_flags", flags, FlFetchLd);
    check_eq("rst_pre_addr", mem_addr, 16'h0405);
    reset_n = 1'b0;
    #1;
    check_eq("rst_async_flags", flags, FlIdle);
    check_eq("rst_async_addr", mem_addr, 16'h0000);
    tick();
    check_eq("rst_hold_flags", flags, FlIdle);
    reset_n = 1'b1;
    tick();
    check_eq("rst_rel_flags", flags, FlIdle);

`ifdef WTS_WATCHDOG_EN
    // Watchdog (WD_BITS = 4): no load_done, expect ERR after 15 WAIT_LOAD cycles
    begin
      int cyc;
      issue(4'd1, 16'h0000);
      repeat (MM) tick();
      check_eq("wd_wait", flags, FlWaitLoad);
      cyc = 0;
      while (!err && cyc < 40) begin
        tick();
        cyc++;
      end
      check_eq("wd_cycles", cyc, 15);
      check_eq("wd_err_flags", flags, 8'hC1);
      tick();
      check_eq("wd_sticky", flags, 8'hC1);
      issue(4'd1, 16'h0500);
      check_eq("wd_restart_flags", flags, FlFetch);
      check_eq("wd_restart_addr", mem_addr, 16'h0500);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
